// File: rtl/hilo_mult_pkg.sv
// hilo_mult_pkg: shared types and constants for the HI/LO multiply sequencer.
// The optional MULT_SIGNED_EN macro uses absVal() to form operand magnitudes.
package hilo_mult_pkg;

  localparam int OP_W            = 16;
  localparam int PROD_W          = 32;
  localparam int TIMEOUT_DEFAULT = 40;
  localparam int CNT_W_DEFAULT   = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  // Two's complement magnitude; 0x8000 maps to itself and is read as unsigned 32768.
  function automatic logic [OP_W-1:0] absVal(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? (~v + OP_W'(1)) : v;
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: HI/LO register pair with MTHI/MTLO writes, product write and the
// MFHI/MFLO read mux. The write enables are qualified by the sequencer.
module hilo_regs
  import hilo_mult_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hiWe,
  input  logic              i_loWe,
  input  logic [OP_W-1:0]   i_wrData,
  input  logic              i_prodWe,
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_mfHi,
  input  logic              i_mfLo,
  output logic [OP_W-1:0]   o_rdData
);

  logic [OP_W-1:0] r_hi;
  logic [OP_W-1:0] r_lo;

  // A finished product overwrites both halves; otherwise MTHI/MTLO load WrData.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_prodWe) begin
      r_hi <= i_prod[PROD_W-1:OP_W];
      r_lo <= i_prod[OP_W-1:0];
    end else begin
      if (i_hiWe) r_hi <= i_wrData;
      if (i_loWe) r_lo <= i_wrData;
    end
  end

  // HI wins when both reads are requested; no read returns zero.
  always_comb begin
    o_rdData = '0;
    if (i_mfHi)      o_rdData = r_hi;
    else if (i_mfLo) o_rdData = r_lo;
  end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: sequencer between the execute stage and the shift-add
// multiplicador. Latches operands, pulses St once the multiplier is idle,
// waits for a fresh Done, then writes the product into HI/LO while stalling
// the pipeline. Optional macro MULT_SIGNED_EN enables two's complement operands.
module hilo_mult_ctrl
  import hilo_mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W          = CNT_W_DEFAULT
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_MultReq,
  input  logic [OP_W-1:0]   i_OpA,
  input  logic [OP_W-1:0]   i_OpB,
  input  logic              i_MfHi,
  input  logic              i_MfLo,
  input  logic              i_MtHi,
  input  logic              i_MtLo,
  input  logic [OP_W-1:0]   i_WrData,
  output logic [OP_W-1:0]   o_RdData,
  output logic              o_Stall,
  output logic              o_Busy,
  output logic              o_Err,
  output logic              o_St,
  output logic [OP_W-1:0]   o_Multiplicando,
  output logic [OP_W-1:0]   o_Multiplicador,
  input  logic              i_Idle,
  input  logic              i_Done,
  input  logic [PROD_W-1:0] i_Produto
);

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_armed;
  logic              r_st;
  logic              r_err;
  logic [OP_W-1:0]   r_mcand;
  logic [OP_W-1:0]   r_mplier;
  logic [PROD_W-1:0] r_prod;

  logic              w_timeout;
  logic              w_accept;
  logic              w_launch;
  logic              w_capture;
  logic              w_hiWe;
  logic              w_loWe;
  logic              w_prodWe;
  logic [OP_W-1:0]   w_opA;
  logic [OP_W-1:0]   w_opB;
  logic [PROD_W-1:0] w_prodFinal;

  assign w_timeout = ((r_state == S_LAUNCH) || (r_state == S_WAIT)) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign w_accept  = (r_state == S_IDLE) && i_MultReq;
  assign w_launch  = (r_state == S_LAUNCH) && !w_timeout && i_Idle;
  assign w_capture = (r_state == S_WAIT) && !w_timeout && r_armed && i_Done;

  // Moves to HI/LO only happen in idle and lose to a same-cycle MultReq.
  assign w_hiWe   = (r_state == S_IDLE) && !i_MultReq && i_MtHi;
  assign w_loWe   = (r_state == S_IDLE) && !i_MultReq && i_MtLo;
  assign w_prodWe = (r_state == S_WRITE);

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // Remember the result sign at acceptance; the multiplier only sees magnitudes.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)         r_neg <= 1'b0;
    else if (w_accept) r_neg <= i_OpA[OP_W-1] ^ i_OpB[OP_W-1];
  end

  assign w_opA       = absVal(i_OpA);
  assign w_opB       = absVal(i_OpB);
  assign w_prodFinal = r_neg ? (~r_prod + PROD_W'(1)) : r_prod;
`else
  assign w_opA       = i_OpA;
  assign w_opB       = i_OpB;
  assign w_prodFinal = r_prod;
`endif

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic; the timeout check beats both launch and capture.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (i_MultReq) w_nextState = S_LAUNCH;
      S_LAUNCH: begin
        if (w_timeout)   w_nextState = S_IDLE;
        else if (i_Idle) w_nextState = S_WAIT;
      end
      S_WAIT: begin
        if (w_timeout)      w_nextState = S_IDLE;
        else if (w_capture) w_nextState = S_WRITE;
      end
      S_WRITE:  w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Operand latch, timeout counter, St pulse, Done arming and product capture.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      r_st     <= 1'b0;
      r_err    <= 1'b0;
      r_prod   <= '0;
    end else begin
      r_st <= w_launch;
      if (w_accept) begin
        r_mcand  <= w_opA;
        r_mplier <= w_opB;
        r_err    <= 1'b0;
        r_cnt    <= '0;
      end
      if ((r_state == S_LAUNCH) || (r_state == S_WAIT)) begin
        if (w_timeout) r_err <= 1'b1;
        else           r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_launch) r_armed <= 1'b0;
      if ((r_state == S_WAIT) && !w_timeout && !i_Done) r_armed <= 1'b1;
      if (w_capture) r_prod <= i_Produto;
    end
  end

  hilo_regs u_regs (
    .i_clk    (i_Clk),
    .i_rst    (i_Rst),
    .i_hiWe   (w_hiWe),
    .i_loWe   (w_loWe),
    .i_wrData (i_WrData),
    .i_prodWe (w_prodWe),
    .i_prod   (w_prodFinal),
    .i_mfHi   (i_MfHi),
    .i_mfLo   (i_MfLo),
    .o_rdData (o_RdData)
  );

  assign o_Busy          = (r_state != S_IDLE);
  assign o_Stall         = o_Busy & (i_MultReq | i_MfHi | i_MfLo | i_MtHi | i_MtLo);
  assign o_Err           = r_err;
  assign o_St            = r_st;
  assign o_Multiplicando = r_mcand;
  assign o_Multiplicador = r_mplier;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// tb_hilo_mult_ctrl: directed bench for hilo_mult_ctrl with a behavioural
// shift-add multiplier that holds Done until the next St.
// Define MULT_SIGNED_EN to also run the signed vectors.
module tb_hilo_mult_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        multReq;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        mfHi;
  logic        mfLo;
  logic        mtHi;
  logic        mtLo;
  logic [15:0] wrData;
  logic [15:0] rdData;
  logic        stall;
  logic        busy;
  logic        err;
  logic        st;
  logic [15:0] mcand;
  logic [15:0] mplier;

  logic        mIdle  = 1'b1;
  logic        mDone  = 1'b0;
  logic [31:0] mProd  = '0;
  logic        mBusy  = 1'b0;
  int          mCnt   = 0;
  logic [15:0] mA     = '0;
  logic [15:0] mB     = '0;
  logic        noDone = 1'b0;

  int   stCount  = 0;
  int   stDouble = 0;
  logic prevSt   = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int stBefore;

  always #5 clk = ~clk;

  hilo_mult_ctrl dut (
    .i_Clk           (clk),
    .i_Rst           (rst),
    .i_MultReq       (multReq),
    .i_OpA           (opA),
    .i_OpB           (opB),
    .i_MfHi          (mfHi),
    .i_MfLo          (mfLo),
    .i_MtHi          (mtHi),
    .i_MtLo          (mtLo),
    .i_WrData        (wrData),
    .o_RdData        (rdData),
    .o_Stall         (stall),
    .o_Busy          (busy),
    .o_Err           (err),
    .o_St            (st),
    .o_Multiplicando (mcand),
    .o_Multiplicador (mplier),
    .i_Idle          (mIdle),
    .i_Done          (mDone),
    .i_Produto       (mProd)
  );

  // Multiplier model: starts on St when idle, has no reset, holds Done until the next St.
  always @(posedge clk) begin
    if (st && !mBusy) begin
      mBusy <= 1'b1;
      mIdle <= 1'b0;
      mDone <= 1'b0;
      mCnt  <= LAT;
      mA    <= mcand;
      mB    <= mplier;
    end else if (mBusy) begin
      if (mCnt == 1) begin
        mBusy <= 1'b0;
        mIdle <= 1'b1;
        mDone <= !noDone;
        mProd <= {16'd0, mA} * {16'd0, mB};
      end
      mCnt <= mCnt - 1;
    end
  end

  // Track St pulses and any back-to-back St cycles.
  always @(posedge clk) begin
    if (st) stCount <= stCount + 1;
    if (st && prevSt) stDouble <= stDouble + 1;
    prevSt <= st;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitNotBusy(input string tag, input int maxCycles);
    int k;
    k = 0;
    while (busy && (k < maxCycles)) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic waitNoStall(input string tag, input int maxCycles);
    int k;
    k = 0;
    while (stall && (k < maxCycles)) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, {31'd0, stall}, 32'd0);
  endtask

  // Directed sequence: reset, basic op, back-to-back, max operands, moves, timeout, reset abort.
  initial begin
    rst = 1'b1; multReq = 1'b0; opA = '0; opB = '0;
    mfHi = 1'b0; mfLo = 1'b0; mtHi = 1'b0; mtLo = 1'b0; wrData = '0;
    applyStimulus(2);
    checkOutput("rstBusy",   {31'd0, busy},  32'd0);
    checkOutput("rstErr",    {31'd0, err},   32'd0);
    checkOutput("rstSt",     {31'd0, st},    32'd0);
    checkOutput("rstMcand",  {16'd0, mcand}, 32'd0);
    checkOutput("rstMplier", {16'd0, mplier},32'd0);
    rst = 1'b0;
    mfHi = 1'b1;
    applyStimulus(1);
    checkOutput("rstHi", {16'd0, rdData}, 32'd0);
    mfHi = 1'b0; mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("rstLo", {16'd0, rdData}, 32'd0);
    mfLo = 1'b0;

    // 12 * 10
    stBefore = stCount;
    multReq = 1'b1; opA = 16'd12; opB = 16'd10;
    applyStimulus(1);
    multReq = 1'b0;
    checkOutput("op1Busy",  {31'd0, busy},  32'd1);
    checkOutput("op1Mcand", {16'd0, mcand}, 32'd12);
    checkOutput("op1Mplier",{16'd0, mplier},32'd10);
    waitNotBusy("op1Done", 40);
    mfHi = 1'b1;
    applyStimulus(1);
    checkOutput("op1Hi", {16'd0, rdData}, 32'h0000);
    mfHi = 1'b0; mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("op1Lo",    {16'd0, rdData}, 32'd120);
    checkOutput("op1Stall", {31'd0, stall},  32'd0);
    checkOutput("op1StCnt", stCount - stBefore, 32'd1);
    mfLo = 1'b0;

    // 12 * 0 then 200 * 3 back to back; second request held by Stall
    multReq = 1'b1; opA = 16'd12; opB = 16'd0;
    applyStimulus(1);
    opA = 16'd200; opB = 16'd3; mfLo = 1'b1;
    checkOutput("b2bStall", {31'd0, stall}, 32'd1);
    waitNoStall("b2bRelease", 40);
    checkOutput("b2bLo1", {16'd0, rdData}, 32'd0);
    applyStimulus(1);
    multReq = 1'b0;
    checkOutput("b2bMplier", {16'd0, mplier}, 32'd3);
    waitNotBusy("b2bDone", 40);
    checkOutput("b2bLo2", {16'd0, rdData}, 32'd600);
    mfLo = 1'b0;

    // 0xFFFF * 0xFFFF with MFLO issued mid-operation
    multReq = 1'b1; opA = 16'hFFFF; opB = 16'hFFFF;
    applyStimulus(1);
    multReq = 1'b0; mfLo = 1'b1;
    checkOutput("maxStall", {31'd0, stall}, 32'd1);
    waitNotBusy("maxDone", 40);
    checkOutput("maxStallOff", {31'd0, stall}, 32'd0);
    checkOutput("maxLo", {16'd0, rdData}, 32'h0001);
    mfHi = 1'b1;
    applyStimulus(1);
`ifdef MULT_SIGNED_EN
    checkOutput("maxHiBoth", {16'd0, rdData}, 32'h0000);
`else
    checkOutput("maxHiBoth", {16'd0, rdData}, 32'hFFFE);
`endif
    mfHi = 1'b0; mfLo = 1'b0;

    // MTHI / MTLO in idle, then MTLO dropped against MultReq
    mtHi = 1'b1; wrData = 16'h1234;
    applyStimulus(1);
    mtHi = 1'b0; mtLo = 1'b1; wrData = 16'h5678;
    applyStimulus(1);
    mtLo = 1'b0;
    checkOutput("mtNoRead", {16'd0, rdData}, 32'd0);
    mfHi = 1'b1;
    applyStimulus(1);
    checkOutput("mtHi", {16'd0, rdData}, 32'h1234);
    mfHi = 1'b0; mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("mtLo", {16'd0, rdData}, 32'h5678);
    mfLo = 1'b0;
    mtLo = 1'b1; wrData = 16'hAAAA; multReq = 1'b1; opA = 16'd3; opB = 16'd7;
    applyStimulus(1);
    mtLo = 1'b0; multReq = 1'b0;
    waitNotBusy("mtDropDone", 40);
    mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("mtDropLo", {16'd0, rdData}, 32'd21);
    mfLo = 1'b0;

    // Done never returns: timeout sets Err and leaves HI/LO alone
    noDone = 1'b1;
    multReq = 1'b1; opA = 16'd5; opB = 16'd5;
    applyStimulus(1);
    multReq = 1'b0;
    applyStimulus(30);
    checkOutput("toStillBusy", {31'd0, busy}, 32'd1);
    checkOutput("toNoErrYet",  {31'd0, err},  32'd0);
    waitNotBusy("toAbort", 30);
    checkOutput("toErr", {31'd0, err}, 32'd1);
    mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("toLoKept", {16'd0, rdData}, 32'd21);
    checkOutput("toErrSticky", {31'd0, err}, 32'd1);
    mfLo = 1'b0;
    noDone = 1'b0;

    // New request clears Err; reset while in S_WAIT aborts everything
    multReq = 1'b1; opA = 16'd2; opB = 16'd3;
    applyStimulus(1);
    multReq = 1'b0;
    checkOutput("errCleared", {31'd0, err}, 32'd0);
    applyStimulus(2);
    checkOutput("preRstBusy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("midRstBusy",  {31'd0, busy},   32'd0);
    checkOutput("midRstSt",    {31'd0, st},     32'd0);
    checkOutput("midRstMcand", {16'd0, mcand},  32'd0);
    checkOutput("midRstMplier",{16'd0, mplier}, 32'd0);
    mfHi = 1'b1; mfLo = 1'b1;
    checkOutput("midRstHi", {16'd0, rdData}, 32'd0);
    mfHi = 1'b0;
    checkOutput("midRstLo", {16'd0, rdData}, 32'd0);
    mfLo = 1'b0;

    // Launch right after reset must still wait for the multiplier to go idle
    stBefore = stCount;
    multReq = 1'b1; opA = 16'd7; opB = 16'd9;
    applyStimulus(1);
    multReq = 1'b0;
    waitNotBusy("postRstDone", 60);
    mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("postRstLo",    {16'd0, rdData}, 32'd63);
    checkOutput("postRstStCnt", stCount - stBefore, 32'd1);
    mfLo = 1'b0;

`ifdef MULT_SIGNED_EN
    // (-3) * 5
    multReq = 1'b1; opA = 16'hFFFD; opB = 16'd5;
    applyStimulus(1);
    multReq = 1'b0;
    checkOutput("sgnMcand", {16'd0, mcand}, 32'd3);
    waitNotBusy("sgn1Done", 40);
    mfHi = 1'b1;
    applyStimulus(1);
    checkOutput("sgn1Hi", {16'd0, rdData}, 32'hFFFF);
    mfHi = 1'b0; mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("sgn1Lo", {16'd0, rdData}, 32'hFFF1);
    mfLo = 1'b0;
    // (-4) * (-4)
    multReq = 1'b1; opA = 16'hFFFC; opB = 16'hFFFC;
    applyStimulus(1);
    multReq = 1'b0;
    waitNotBusy("sgn2Done", 40);
    mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("sgn2Lo", {16'd0, rdData}, 32'd16);
    mfLo = 1'b0; mfHi = 1'b1;
    applyStimulus(1);
    checkOutput("sgn2Hi", {16'd0, rdData}, 32'h0000);
    mfHi = 1'b0;
    // (-32768) * 1
    multReq = 1'b1; opA = 16'h8000; opB = 16'd1;
    applyStimulus(1);
    multReq = 1'b0;
    checkOutput("sgnMinMag", {16'd0, mcand}, 32'h8000);
    waitNotBusy("sgn3Done", 40);
    mfHi = 1'b1;
    applyStimulus(1);
    checkOutput("sgn3Hi", {16'd0, rdData}, 32'hFFFF);
    mfHi = 1'b0; mfLo = 1'b1;
    applyStimulus(1);
    checkOutput("sgn3Lo", {16'd0, rdData}, 32'h8000);
    mfLo = 1'b0;
`endif

    checkOutput("stSinglePulse", stDouble, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
- Sequencer between the pipeline execute stage and the shift-add multiplicador.
- Accepts MULT requests, latches the operands, pulses St, and waits for Done.
- Captures the 32-bit Produto into the HI/LO registers and stalls the pipeline while busy.
- Also serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- TIMEOUT_CYCLES, 40: max cycles in LAUNCH+WAIT before abort.
- CNT_W, 6: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, synchronous, active-high.
- MultReq  in  1  start multiply with OpA*OpB.
- OpA  in  16  multiplicand.
- OpB  in  16  multiplier.
- MfHi  in  1  read HI.
- MfLo  in  1  read LO.
- MtHi  in  1  write WrData into HI.
- MtLo  in  1  write WrData into LO.
- WrData  in  16  MTHI/MTLO data.
- RdData  out  16  HI when MfHi, else LO when MfLo, else 0 (combinational).
- Stall  out  1  pipeline hold.
- Busy  out  1  state != S_IDLE.
- Err  out  1  sticky timeout flag; cleared by Rst or the next accepted MultReq.
- St  out  1  start pulse to multiplicador.
- Multiplicando  out  16  latched operand A.
- Multiplicador  out  16  latched operand B.
- Idle  in  1  multiplicador idle.
- Done  in  1  multiplicador result valid.
- Produto  in  32  multiplicador result.

Behaviour:
- Reset values (on the first Clk edge with Rst=1):
  - state=S_IDLE.
  - HI=0, LO=0.
  - St=0, Err=0.
  - Multiplicando=0, Multiplicador=0.
  - armed=0, cnt=0.
- States: S_IDLE, S_LAUNCH, S_WAIT, S_WRITE.
- S_IDLE:
  - MultReq=1: latch OpA/OpB, clear Err, cnt=0, go to S_LAUNCH.
  - Else MtHi/MtLo write HI/LO on this edge.
  - MultReq has priority; Mt* in the same cycle is dropped.
- S_LAUNCH:
  - Wait for Idle=1.
  - On Idle=1, St=1 for exactly one cycle, armed=0, go to S_WAIT.
  - St is registered and never high outside this single cycle.
- S_WAIT:
  - armed sets the first cycle Done=0 is seen. This rejects a Done level held over from the previous operation.
  - When armed=1 and Done=1, register Produto and go to S_WRITE.
- S_WRITE: HI<=Produto[31:16], LO<=Produto[15:0], go to S_IDLE. Result is readable the cycle after S_WRITE.
- Latency: request to HI/LO valid = 1 + Idle wait + multiplicador latency + 1.
- Timeout:
  - cnt increments in S_LAUNCH and S_WAIT.
  - cnt==TIMEOUT_CYCLES: Err=1, go to S_IDLE, HI/LO unchanged.
- Stall = Busy & (MultReq|MfHi|MfLo|MtHi|MtLo).
  - Reads and writes while busy are held until S_IDLE. Mt* is never lost while busy.
  - MultReq during busy is held, not queued.
- RdData is valid in S_IDLE only; it shows the pre-write value during S_WRITE (Stall covers it).
- MfHi and MfLo together: HI is returned.
- Rst mid-operation:
  - Aborts to the reset values.
  - multiplicador has no reset, so the next launch still gates on Idle=1.

Optional Feature:
- Macro MULT_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - Magnitudes are sent to the multiplicador; the sign is stored at acceptance.
  - Produto is negated (32-bit two's complement) in S_WRITE when the signs differ.
  - Abs(-32768) = 0x8000, treated as unsigned 32768.
- Undefined: unsigned only; no sign logic.

Decomposition:
- Package hilo_mult_pkg holds:
  - state encoding S_IDLE..S_WRITE (2 bits);
  - widths OP_W=16, PROD_W=32;
  - TIMEOUT default.
- Sub-module hilo_regs: HI/LO storage, Mt* write, product write, RdData mux. The FSM stays in the top level.

Test Plan:
- MultReq with OpA=12, OpB=10 → one St pulse after Idle; HI=0x0000, LO=120; Busy drops; Stall=0 afterwards.
- 12*0, then 200*3, back-to-back (second request held by Stall) → LO=0, then LO=600; the stale Done from the first op must not capture early.
- OpA=0xFFFF, OpB=0xFFFF → HI=0xFFFE, LO=0x0001; MfLo issued mid-op stalls, then RdData=0x0001.
- MtHi WrData=0x1234 and MtLo 0x5678 in idle → MfHi=0x1234, MfLo=0x5678; MtLo together with MultReq → Mt dropped, LO=product.
- Done tied 0 → Err=1 after 40 cycles, HI/LO unchanged; Rst asserted in S_WAIT → all reset values next edge.
- With MULT_SIGNED_EN: OpA=-3 (0xFFFD), OpB=5 → HI=0xFFFF, LO=0xFFF1; (-4)*(-4) → LO=16.
